echo_seq_ctrl: RTL and testbench
================================

Name: echo_seq_ctrl

Overview:
- Sequences the echo delay-line datapath: turns the ADC data_valid level into one-cycle sample strobes and generates read/write strobes and addresses for an external single-clock sample RAM used as a circular delay buffer.
- Holds the programmable echo delay taken from the board switches and raises echo_en only once the buffer holds a full delay's worth of samples.
- Sits between the ADC/DAC interface and the echo arithmetic. While echo_en = 0, the arithmetic treats the buffer output as zero.

Parameters:
ADDR_W, 10, RAM address width; buffer depth DEPTH = 2^ADDR_W samples
DEL_W, 10, width of delay_sel input

Ports:
sysclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_valid  in  1  ADC sample-valid level, synchronous to sysclk
delay_sel  in  DEL_W  requested echo delay in samples (switches)
sample_strobe  out  1  one-cycle pulse per accepted sample
ram_re  out  1  RAM read enable (read data valid the following cycle)
ram_raddr  out  ADDR_W  RAM read address
ram_we  out  1  RAM write enable (datapath writes y)
ram_waddr  out  ADDR_W  RAM write address
echo_en  out  1  buffer primed; datapath may use RAM read data
overrun  out  1  sticky: a sample edge arrived while busy
busy  out  1  high in READ, WAIT and WRITE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; wp = 0; fill_cnt = 0; d_cur = 1.
  - dv_prev = 1, so a data_valid already high at reset release produces no strobe.
  - All outputs 0.
- Edge detect:
  - dv_prev is a register of data_valid.
  - A rising edge is data_valid = 1 with dv_prev = 0, sampled at a sysclk edge.
- Delay clamp:
  - d_req = delay_sel, forced to 1 if 0, and to DEPTH-1 if above DEPTH-1.
- FSM states: IDLE, READ, WAIT, WRITE. All outputs registered.
- IDLE:
  - If d_req != d_cur: load d_cur = d_req and clear fill_cnt = 0 (echo_en drops next cycle).
  - If a rising edge is detected: go to READ. A delay change and an edge on the same cycle are both applied; the sample uses the new d_cur and a zero fill_cnt.
- READ, one cycle:
  - sample_strobe = 1, ram_re = 1, busy = 1.
  - ram_raddr = (wp - d_cur) mod DEPTH, computed as an ADDR_W-bit wrap subtraction.
- WAIT, one cycle:
  - RAM data is valid; the datapath forms y.
  - busy = 1; ram_re = 0.
- WRITE, one cycle:
  - ram_we = 1, ram_waddr = wp, busy = 1.
  - On exit: wp = wp + 1 mod DEPTH (wraps from DEPTH-1 to 0); fill_cnt increments, saturating at d_cur. Return to IDLE.
- Timing:
  - A strobe accepted at cycle T gives READ at T, WAIT at T+1, WRITE at T+2.
  - The earliest next READ is T+4 (IDLE at T+3 evaluates the next edge).
- echo_en:
  - Registered; echo_en = (fill_cnt == d_cur).
  - Holds through READ/WAIT/WRITE of a sample.
  - Becomes 1 in the cycle after the WRITE that brings fill_cnt to d_cur.
- delay_sel is ignored outside IDLE; a change is applied at the next IDLE cycle.
- Overrun: a rising edge detected in READ, WAIT or WRITE is dropped and sets overrun = 1 (sticky until reset). An edge coincident with the WRITE→IDLE transition is also dropped.
- Reset mid-sample: the operation is aborted immediately, with no ram_we, and the primed state is lost.
- wp never stalls; RAM contents are not cleared. Stale data is masked only by echo_en.

Test Plan:
- Reset release with data_valid held 1 -> no sample_strobe until data_valid goes 0 then 1; all outputs 0 through reset.
- delay_sel = 3, four data_valid pulses 20 cycles apart -> per sample: ram_re at T, ram_we at T+2; raddr/waddr = 1021/0, 1022/1, 1023/2, 0/3; echo_en rises after the 3rd WRITE and is 1 for the 4th sample.
- delay_sel = 0 -> d_cur = 1; first raddr = 1023; echo_en = 1 after the first WRITE.
- Wrap: 1030 samples with delay 5 -> waddr wraps 1023→0; raddr always equals waddr - 5 mod 1024.
- Primed at delay 5, then delay_sel = 8 -> echo_en = 0 one cycle later (IDLE); re-primes after exactly 8 WRITEs; a change applied during WAIT takes effect in the following IDLE.
- data_valid edges 2 cycles apart -> the second edge is dropped with no extra ram_we and overrun = 1; overrun stays 1 until rst_n low.

Source files
------------

// File: rtl/echo_seq_ctrl_if.sv
// Echo sequencer bus: ADC-side sample timing and switch delay in, RAM strobes/addresses and
// status out.
//   data_valid    ADC sample-valid level
//   delay_sel     requested echo delay in samples
//   sample_strobe one-cycle pulse per accepted sample
//   ram_re/raddr  RAM read enable and address (data valid next cycle)
//   ram_we/waddr  RAM write enable and address
//   echo_en       buffer holds a full delay's worth of samples
//   overrun       sticky: sample edge arrived while busy
//   busy          sample operation in progress
// master: the ADC/datapath side that drives data_valid/delay_sel. slave: the controller.
interface echo_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEL_W  = 10
);
  logic              data_valid;
  logic [DEL_W-1:0]  delay_sel;
  logic              sample_strobe;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              echo_en;
  logic              overrun;
  logic              busy;

  modport master (
    output data_valid, delay_sel,
    input  sample_strobe, ram_re, ram_raddr, ram_we, ram_waddr, echo_en, overrun, busy
  );

  modport slave (
    input  data_valid, delay_sel,
    output sample_strobe, ram_re, ram_raddr, ram_we, ram_waddr, echo_en, overrun, busy
  );
endinterface

// File: rtl/echo_seq_ctrl.sv
// Echo delay-line sequencer. Converts the ADC data_valid level into sample operations
// (READ, WAIT, WRITE) against an external circular sample RAM, tracks the programmed delay
// and reports when the buffer is primed.
//   sysclk  system clock (rising edge)
//   rst_n   asynchronous active-low reset
//   bus     echo_seq_ctrl_if slave modport (see interface for signal list)
module echo_seq_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEL_W  = 10
) (
  input logic            sysclk,
  input logic            rst_n,
  echo_seq_ctrl_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

  state_e            state_q, state_d;
  logic              dv_prev_q;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] d_cur_q, d_cur_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              overrun_q, overrun_d;
  logic              strobe_q, we_q, echo_en_q, busy_q;
  logic [ADDR_W-1:0] d_req;
  logic [31:0]       sel_ext;
  logic              dv_rise;

  assign dv_rise = bus.data_valid & ~dv_prev_q;
  assign sel_ext = 32'(bus.delay_sel);

  // A zero delay would read the slot being written; clamp into 1..Depth-1.
  always_comb begin
    d_req = ADDR_W'(sel_ext);
    if (sel_ext == 32'd0) begin
      d_req = ADDR_W'(1);
    end else if (sel_ext > 32'(Depth - 1)) begin
      d_req = '1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    fill_d    = fill_q;
    d_cur_d   = d_cur_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    overrun_d = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (d_req != d_cur_q) begin
          d_cur_d = d_req;
          fill_d  = '0;
        end
        if (dv_rise) begin
          state_d = StRead;
          // Uses the delay loaded this same cycle.
          raddr_d = wp_q - d_cur_d;
        end
      end
      StRead: begin
        state_d = StWait;
        if (dv_rise) overrun_d = 1'b1;
      end
      StWait: begin
        state_d = StWrite;
        waddr_d = wp_q;
        if (dv_rise) overrun_d = 1'b1;
      end
      StWrite: begin
        state_d = StIdle;
        wp_d    = wp_q + ADDR_W'(1);
        if (fill_q != d_cur_q) fill_d = fill_q + ADDR_W'(1);
        // Edge on the WRITE->IDLE transition is dropped too.
        if (dv_rise) overrun_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state so they line up with the state they decode.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dv_prev_q <= 1'b1;
      wp_q      <= '0;
      fill_q    <= '0;
      d_cur_q   <= ADDR_W'(1);
      raddr_q   <= '0;
      waddr_q   <= '0;
      overrun_q <= 1'b0;
      strobe_q  <= 1'b0;
      we_q      <= 1'b0;
      echo_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dv_prev_q <= bus.data_valid;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      d_cur_q   <= d_cur_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      overrun_q <= overrun_d;
      strobe_q  <= (state_d == StRead);
      we_q      <= (state_d == StWrite);
      echo_en_q <= (fill_d == d_cur_d);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus.sample_strobe = strobe_q;
  assign bus.ram_re        = strobe_q;
  assign bus.ram_raddr     = raddr_q;
  assign bus.ram_we        = we_q;
  assign bus.ram_waddr     = waddr_q;
  assign bus.echo_en       = echo_en_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_echo_seq_ctrl.sv
module tb_echo_seq_ctrl;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;

  echo_seq_ctrl_if #(.ADDR_W(10), .DEL_W(10)) bus ();

  echo_seq_ctrl #(.ADDR_W(10), .DEL_W(10)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [9:0] raddr;
    logic [9:0] waddr;
    logic       en_rd;
    logic       en_after;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_sample(input int raddr, input int waddr, input bit en_rd,
                               input bit en_after);
    exp_t e;
    e.raddr    = 10'(raddr);
    e.waddr    = 10'(waddr);
    e.en_rd    = en_rd;
    e.en_after = en_after;
    sb_q.push_back(e);
  endtask

  // Monitor: every read pops one expected sample; its write must follow two cycles later.
  logic       pend_valid = 1'b0;
  int         pend_wcyc  = 0;
  logic [9:0] pend_waddr = '0;
  logic       pend_en    = 1'b0;
  logic       en_chk     = 1'b0;
  logic       en_exp     = 1'b0;

  always @(negedge sysclk) begin
    exp_t e;
    if (en_chk) begin
      chk("echo_en_after_write", 32'(bus.echo_en), 32'(en_exp));
      en_chk = 1'b0;
    end
    if (bus.ram_re) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("raddr", 32'(bus.ram_raddr), 32'(e.raddr));
        chk("echo_en_at_read", 32'(bus.echo_en), 32'(e.en_rd));
        chk("strobe_with_read", 32'(bus.sample_strobe), 32'd1);
        chk("busy_at_read", 32'(bus.busy), 32'd1);
        pend_valid = 1'b1;
        pend_wcyc  = cyc + 2;
        pend_waddr = e.waddr;
        pend_en    = e.en_after;
      end
    end
    if (bus.ram_we) begin
      if (!pend_valid || cyc != pend_wcyc) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        chk("waddr", 32'(bus.ram_waddr), 32'(pend_waddr));
        en_chk     = 1'b1;
        en_exp     = pend_en;
        pend_valid = 1'b0;
      end
    end else if (pend_valid && cyc > pend_wcyc) begin
      chk("missing_write", 32'd0, 32'd1);
      pend_valid = 1'b0;
    end
  end

  task automatic do_reset(input logic dv_level, input int dsel);
    @(negedge sysclk);
    rst_n          = 1'b0;
    bus.data_valid = dv_level;
    bus.delay_sel  = 10'(dsel);
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_flags", {26'd0, bus.sample_strobe, bus.ram_re, bus.ram_we, bus.echo_en,
                        bus.overrun, bus.busy}, 32'd0);
    chk("reset_addrs", {12'd0, bus.ram_raddr, bus.ram_waddr}, 32'd0);
    @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse(input int gap);
    @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    repeat (gap) @(posedge sysclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.data_valid = 1'b0;
    bus.delay_sel  = '0;

    // data_valid high across reset release: no strobe until it toggles.
    do_reset(1'b1, 3);
    for (int i = 0; i < 6; i++) begin
      @(posedge sysclk);
      #1 chk("no_strobe_dv_held", 32'(bus.sample_strobe), 32'd0);
    end
    bus.data_valid = 1'b0;
    repeat (3) @(posedge sysclk);

    // Delay 3, four samples.
    expect_sample(1021, 0, 0, 0);
    expect_sample(1022, 1, 0, 0);
    expect_sample(1023, 2, 0, 1);
    expect_sample(0,    3, 1, 1);
    for (int i = 0; i < 4; i++) pulse(18);
    #1 chk("no_overrun_spaced", 32'(bus.overrun), 32'd0);

    // Delay 0 clamps to 1.
    do_reset(1'b0, 0);
    expect_sample(1023, 0, 0, 1);
    expect_sample(0,    1, 1, 1);
    for (int i = 0; i < 2; i++) pulse(6);

    // Wrap with delay 5.
    do_reset(1'b0, 5);
    for (int i = 0; i < 1030; i++) begin
      expect_sample((i + 1024 - 5) % 1024, i % 1024, i >= 5, i >= 4);
      pulse(4);
    end

    // Primed at 5; change to 8 drops echo_en after one IDLE cycle.
    #1 chk("primed_d5", 32'(bus.echo_en), 32'd1);
    bus.delay_sel = 10'd8;
    @(posedge sysclk);
    #1 chk("echo_en_drop_d8", 32'(bus.echo_en), 32'd0);
    for (int i = 0; i < 8; i++) begin
      expect_sample((6 + i + 1024 - 8) % 1024, 6 + i, 0, i == 7);
      pulse(4);
    end

    // Delay change while in WAIT waits for the following IDLE.
    expect_sample(6, 14, 1, 1);
    @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    @(posedge sysclk);
    #1 bus.delay_sel = 10'd2;
    chk("busy_in_wait", 32'(bus.busy), 32'd1);
    repeat (3) @(posedge sysclk);
    #1 chk("echo_en_drop_after_wait_change", 32'(bus.echo_en), 32'd0);
    expect_sample(13, 15, 0, 0);
    expect_sample(14, 16, 0, 1);
    for (int i = 0; i < 2; i++) pulse(4);

    // Edges two cycles apart: second lands in WAIT and is dropped.
    do_reset(1'b0, 1);
    chk("overrun_clear_after_reset", 32'(bus.overrun), 32'd0);
    expect_sample(1023, 0, 0, 1);
    @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    repeat (6) @(posedge sysclk);
    #1 chk("overrun_set", 32'(bus.overrun), 32'd1);
    expect_sample(0, 1, 1, 1);
    pulse(6);
    #1 chk("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Edge coincident with WRITE->IDLE is dropped.
    do_reset(1'b0, 1);
    chk("overrun_clear_again", 32'(bus.overrun), 32'd0);
    expect_sample(1023, 0, 0, 1);
    @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 bus.data_valid = 1'b1;
    @(posedge sysclk);
    #1 bus.data_valid = 1'b0;
    repeat (6) @(posedge sysclk);
    #1 chk("overrun_write_exit", 32'(bus.overrun), 32'd1);

    repeat (10) @(posedge sysclk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    chk("no_pending_write", 32'(pend_valid), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
